// File: rtl/modmul_interleaved_pkg.sv
// Shared constants and FSM encoding for the interleaved modular multiplier.
package modmul_interleaved_pkg;

    localparam int MODMUL_WIDTH = 381;
    localparam int IDX_W        = 9;

    typedef enum logic [2:0] {
        IDLE,
        DBL_GO,
        DBL_WAIT,
        ADD_GO,
        ADD_WAIT,
        NEXT,
        FINISH
    } state_t;

endpackage

// File: rtl/modmul_interleaved_if.sv
// Request/response bundle for the interleaved modular multiplier.
interface modmul_interleaved_if
    import modmul_interleaved_pkg::*;
#(
    parameter int WIDTH = MODMUL_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    modport master (
        output start, in_a, in_b, in_m,
        input  result, done, busy
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output result, done, busy
    );
endinterface

// File: rtl/modadder.sv
// Registered modular adder/subtractor: result = (a +/- b) mod m, done one cycle after start.
module modadder #(
    parameter int WIDTH = 381
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    logic [WIDTH:0]   sum_raw;
    logic [WIDTH-1:0] sum_red;
    logic [WIDTH-1:0] diff_red;
    logic [WIDTH-1:0] result_next;

    always_comb begin
        sum_raw     = {1'b0, in_a} + {1'b0, in_b};
        sum_red     = (sum_raw >= {1'b0, in_m}) ? WIDTH'(sum_raw - {1'b0, in_m})
                                                : sum_raw[WIDTH-1:0];
        // Borrow case folds the modulus back in; wraparound of the WIDTH-bit sum is intended.
        diff_red    = (in_a < in_b) ? (in_a - in_b + in_m) : (in_a - in_b);
        result_next = subtract ? diff_red : sum_red;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                result <= result_next;
            end
        end
    end
endmodule

// File: rtl/modmul_interleaved.sv
// MSB-first double-and-add modular multiplier built around one shared modadder.
module modmul_interleaved
    import modmul_interleaved_pkg::*;
#(
    parameter int WIDTH = MODMUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    modmul_interleaved_if.slave  bus
);
    localparam logic [IDX_W-1:0] TOP_INDEX = IDX_W'(WIDTH - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               done_reg;
    logic               busy_reg;
    logic               add_start_reg;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_result;
    logic               add_done;

    // The adder samples its operands while the FSM sits in a WAIT state.
    assign add_b = (state_reg == ADD_WAIT) ? a_reg : acc_reg;

    modadder #(
        .WIDTH (WIDTH)
    ) u_modadder (
        .clk      (clk),
        .resetn   (~rst),
        .start    (add_start_reg),
        .subtract (1'b0),
        .in_a     (acc_reg),
        .in_b     (add_b),
        .in_m     (m_reg),
        .result   (add_result),
        .done     (add_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            m_reg         <= '0;
            idx_reg       <= '0;
            result_reg    <= '0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            add_start_reg <= 1'b0;
        end else begin
            add_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    // busy is still high in the done cycle, so a start there is ignored.
                    if (bus.start && !busy_reg) begin
                        a_reg     <= bus.in_a;
                        b_reg     <= bus.in_b;
                        m_reg     <= bus.in_m;
                        acc_reg   <= '0;
                        idx_reg   <= TOP_INDEX;
                        busy_reg  <= 1'b1;
                        state_reg <= DBL_GO;
                    end
                end
                DBL_GO: begin
                    add_start_reg <= 1'b1;
                    state_reg     <= DBL_WAIT;
                end
                DBL_WAIT: begin
                    if (add_done) begin
                        acc_reg   <= add_result;
                        state_reg <= b_reg[idx_reg] ? ADD_GO : NEXT;
                    end
                end
                ADD_GO: begin
                    add_start_reg <= 1'b1;
                    state_reg     <= ADD_WAIT;
                end
                ADD_WAIT: begin
                    if (add_done) begin
                        acc_reg   <= add_result;
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_reg == '0) begin
                        state_reg <= FINISH;
                    end else begin
                        idx_reg   <= idx_reg - IDX_W'(1);
                        state_reg <= DBL_GO;
                    end
                end
                FINISH: begin
                    result_reg <= acc_reg;
                    done_reg   <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = busy_reg;
endmodule

// File: tb/tb_modmul_interleaved.sv
// Directed bench for modmul_interleaved with a cycle-level reference model and scoreboard.
module tb_modmul_interleaved;
    import modmul_interleaved_pkg::*;

    localparam int W = MODMUL_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    modmul_interleaved_if #(.WIDTH(W)) bus ();

    modmul_interleaved #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    // Adder latency is one cycle: each bit costs 4 cycles, each set bit 3 more.
    function automatic int exp_latency(input logic [W-1:0] b);
        return W * 4 + $countones(b) * 3 + 2;
    endfunction

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: tracks accepted requests and the exact done cycle expected for each.
    int          cyc = 0;
    int          m_due = 0;
    logic        m_busy = 1'b0;
    logic        m_prev = 1'b0;
    logic        exp_done;
    logic [W-1:0] m_exp = '0;
    logic [W-1:0] m_res = '0;

    always begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_res  = '0;
        end else begin
            m_prev = m_busy;
            if (m_busy && cyc == m_due + 1) m_busy = 1'b0;
            if (!m_prev && bus.start) begin
                m_busy = 1'b1;
                m_due  = cyc + exp_latency(bus.in_b) - 1;
                m_exp  = mulmod(bus.in_a, bus.in_b, bus.in_m);
            end
        end
        #1;
        exp_done = m_busy && !rst && (cyc == m_due);
        check_val("mon_busy", W'(bus.busy), W'(m_busy));
        check_val("mon_done", W'(bus.done), W'(exp_done));
        if (exp_done) m_res = m_exp;
        check_val("mon_result", bus.result, m_res);
    end

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input logic [W-1:0] exp_r, input int exp_lat,
                          input int inject_at);
        int cnt;
        bit got;
        @(negedge clk);
        bus.in_a  = a;
        bus.in_b  = b;
        bus.in_m  = m;
        bus.start = 1'b1;
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 1) begin
                bus.start = 1'b0;
                bus.in_a  = W'(2);
                bus.in_b  = W'(3);
                bus.in_m  = W'(11);
            end
            if (inject_at != 0 && cnt == inject_at) bus.start = 1'b1;
            if (inject_at != 0 && cnt == inject_at + 1) bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        check_int({name, "_done_seen"}, int'(got), 1);
        check_val({name, "_result"}, bus.result, exp_r);
        check_int({name, "_latency"}, cnt, exp_lat);
        @(posedge clk);
        #1;
        check_val({name, "_done_single"}, W'(bus.done), W'(0));
        check_val({name, "_busy_after"}, W'(bus.busy), W'(0));
        $display("op %s: result=%0h latency=%0d", name, bus.result, cnt);
    endtask

    initial begin
        logic [W-1:0] m_all;
        logic [W-1:0] a_top;
        int stray;
        int cnt;

        bus.start = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        bus.in_m  = '0;
        m_all = '1;
        a_top = W'(1) << (W - 1);

        check_val("model_3x5m7", mulmod(W'(3), W'(5), W'(7)), W'(1));
        check_val("model_12x12m13", mulmod(W'(12), W'(12), W'(13)), W'(1));
        check_val("model_top_x2", mulmod(a_top, W'(2), m_all), W'(1));
        check_int("model_lat_b5", exp_latency(W'(5)), 1532);

        repeat (3) @(negedge clk);
        check_val("reset_result", bus.result, W'(0));
        check_val("reset_done", W'(bus.done), W'(0));
        check_val("reset_busy", W'(bus.busy), W'(0));
        rst = 1'b0;

        run_op("basic_3x5m7", W'(3), W'(5), W'(7), W'(1), 1532, 0);
        run_op("12x12m13", W'(12), W'(12), W'(13), W'(1), 1532, 0);
        run_op("b_zero", W'(12), W'(0), W'(13), W'(0), 1526, 0);
        run_op("top_x2", a_top, W'(2), m_all, W'(1), 1529, 0);
        run_op("mm1_sq", m_all - W'(1), m_all - W'(1), m_all, W'(1), 2666, 0);
        run_op("restart_ign", W'(12), W'(12), W'(13), W'(1), 1532, 10);
        repeat (40) @(negedge clk);

        // Abort during the doubling wait of bit 200.
        @(negedge clk);
        bus.in_a  = W'(3);
        bus.in_b  = W'(5);
        bus.in_m  = W'(7);
        bus.start = 1'b1;
        cnt = 0;
        while (cnt < 722) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 1) bus.start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_result", bus.result, W'(0));
        check_val("abort_done", W'(bus.done), W'(0));
        check_val("abort_busy", W'(bus.busy), W'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 1600; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) stray++;
        end
        check_int("abort_no_done", stray, 0);
        $display("op abort_at_bit200: stray_done=%0d", stray);

        run_op("after_reset", W'(3), W'(5), W'(7), W'(1), 1532, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end
endmodule
